// File: rtl/vga_window_ctrl.sv
// rtl/vga_window_ctrl.sv - VGA timing generator with windowed ROM image, colour bars and background fill
module vga_window_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADDR_W   = 16,
    parameter int ROM_LAT  = 1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [1:0]        MODE,
    input  logic [11:0]       WIN_X,
    input  logic [11:0]       WIN_Y,
    input  logic [23:0]       BG_RGB,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [7:0]        ROM_Q,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              FRAME_START
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0]  DIV_HALF = 4'(CLK_DIV / 2);
    localparam int          BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic        HS_ON    = (HS_POL != 0);
    localparam logic        VS_ON    = (VS_POL != 0);

    // Sync flags travel as "active" bits so an all-zero (reset) stage means inactive syncs.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       win;
        logic       origin;
        logic [1:0] mode;
        logic [3:0] bar;
    } meta_t;

    logic [3:0]        div_cnt;
    logic [3:0]        div_next;
    logic              tick;
    logic [11:0]       h_pos;
    logic [11:0]       v_pos;
    logic [1:0]        sh_mode;
    logic [11:0]       sh_win_x;
    logic [11:0]       sh_win_y;
    logic [23:0]       sh_bg;
    logic              origin;
    logic [1:0]        eff_mode;
    logic [11:0]       eff_x;
    logic [11:0]       eff_y;
    logic [11:0]       rel_x;
    logic [11:0]       rel_y;
    logic              active;
    logic              in_x;
    logic              in_y;
    logic [ADDR_W-1:0] addr_next;
    logic [23:0]       rgb_next;
    meta_t             m_new;
    meta_t             m_out;
    meta_t             pipe [ROM_LAT];

    assign tick     = (div_cnt == DIV_LAST);
    assign div_next = tick ? 4'd0 : div_cnt + 4'd1;
    assign origin   = (h_pos == 12'd0) && (v_pos == 12'd0);

    // The pixel at (0,0) already uses the values being captured this tick.
    assign eff_mode = origin ? MODE  : sh_mode;
    assign eff_x    = origin ? WIN_X : sh_win_x;
    assign eff_y    = origin ? WIN_Y : sh_win_y;

    assign active    = (h_pos < H_ACT) && (v_pos < V_ACT);
    assign in_x      = (h_pos >= eff_x) && (32'(h_pos) < 32'(eff_x) + 32'(IMG_W));
    assign in_y      = (v_pos >= eff_y) && (32'(v_pos) < 32'(eff_y) + 32'(IMG_H));
    assign rel_x     = h_pos - eff_x;
    assign rel_y     = v_pos - eff_y;
    assign addr_next = ADDR_W'(32'(rel_y) * 32'(IMG_W) + 32'(rel_x));
    assign m_out     = pipe[ROM_LAT-1];
    assign VGA_SYNC_N = 1'b0;

    always_comb begin
        m_new        = '0;
        m_new.hs     = (h_pos >= HS_START) && (h_pos < HS_END);
        m_new.vs     = (v_pos >= VS_START) && (v_pos < VS_END);
        m_new.act    = active;
        m_new.win    = active && in_x && in_y;
        m_new.origin = origin;
        m_new.mode   = eff_mode;
        m_new.bar    = (32'(h_pos) >= 32'(8 * BAR_W)) ? 4'd8 : 4'(32'(h_pos) / 32'(BAR_W));
    end

    always_comb begin
        rgb_next = 24'd0;
        if (m_out.act) begin
            case (m_out.mode)
                2'd0: rgb_next = m_out.win ?
                          {ROM_Q[7:5], ROM_Q[7:5], ROM_Q[7:6],
                           ROM_Q[4:2], ROM_Q[4:2], ROM_Q[4:3],
                           {4{ROM_Q[1:0]}}} : sh_bg;
                2'd1: begin
                    case (m_out.bar)
                        4'd0:    rgb_next = 24'hFFFFFF;
                        4'd1:    rgb_next = 24'hFFFF00;
                        4'd2:    rgb_next = 24'h00FFFF;
                        4'd3:    rgb_next = 24'h00FF00;
                        4'd4:    rgb_next = 24'hFF00FF;
                        4'd5:    rgb_next = 24'hFF0000;
                        4'd6:    rgb_next = 24'h0000FF;
                        default: rgb_next = 24'h000000;
                    endcase
                end
                default: rgb_next = sh_bg;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            div_cnt     <= 4'd0;
            VGA_CLK     <= 1'b0;
            h_pos       <= 12'd0;
            v_pos       <= 12'd0;
            sh_mode     <= 2'd2;
            sh_win_x    <= 12'd0;
            sh_win_y    <= 12'd0;
            sh_bg       <= 24'd0;
            ROM_ADDR    <= '0;
            for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
            VGA_HS      <= !HS_ON;
            VGA_VS      <= !VS_ON;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
            FRAME_START <= 1'b0;
        end else begin
            div_cnt     <= div_next;
            VGA_CLK     <= (div_next < DIV_HALF);
            FRAME_START <= 1'b0;
            if (tick) begin
                if (h_pos == H_LAST) begin
                    h_pos <= 12'd0;
                    v_pos <= (v_pos == V_LAST) ? 12'd0 : v_pos + 12'd1;
                end else begin
                    h_pos <= h_pos + 12'd1;
                end
                if (origin) begin
                    sh_mode  <= MODE;
                    sh_win_x <= WIN_X;
                    sh_win_y <= WIN_Y;
                    sh_bg    <= BG_RGB;
                end
                ROM_ADDR <= m_new.win ? addr_next : '0;
                pipe[0]  <= m_new;
                for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
                VGA_HS      <= m_out.hs ? HS_ON : !HS_ON;
                VGA_VS      <= m_out.vs ? VS_ON : !VS_ON;
                VGA_BLANK_N <= m_out.act;
                {VGA_R, VGA_G, VGA_B} <= rgb_next;
                FRAME_START <= m_out.origin;
            end
        end
    end
endmodule

// File: tb/tb_vga_window_ctrl.sv
// tb/tb_vga_window_ctrl.sv - directed bench for vga_window_ctrl on a reduced raster
module tb_vga_window_ctrl;
    localparam int H_TOT = 24;
    localparam int V_TOT = 12;

    logic        clk;
    logic        rstn;
    logic [1:0]  mode;
    logic [11:0] win_x, win_y;
    logic [23:0] bg;

    logic [15:0] rom_addr1, rom_addr2;
    logic [7:0]  rom_q1;
    logic [7:0]  rom_p2 [3];
    logic        vga_clk1, hs1, vs1, blank1, sync1, fs1;
    logic        vga_clk2, hs2, vs2, blank2, sync2, fs2;
    logic [7:0]  r1, g1, b1, r2, g2, b2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int cur_div = 2;

    vga_window_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .HS_POL(0), .VS_POL(0),
        .IMG_W(4), .IMG_H(4), .ADDR_W(16), .ROM_LAT(1)
    ) u_dut1 (
        .CLK(clk), .RSTN(rstn), .MODE(mode), .WIN_X(win_x), .WIN_Y(win_y), .BG_RGB(bg),
        .ROM_ADDR(rom_addr1), .ROM_Q(rom_q1), .VGA_CLK(vga_clk1), .VGA_HS(hs1), .VGA_VS(vs1),
        .VGA_BLANK_N(blank1), .VGA_SYNC_N(sync1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
        .FRAME_START(fs1)
    );

    vga_window_ctrl #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(4), .HS_POL(0), .VS_POL(0),
        .IMG_W(4), .IMG_H(4), .ADDR_W(16), .ROM_LAT(3)
    ) u_dut2 (
        .CLK(clk), .RSTN(rstn), .MODE(mode), .WIN_X(win_x), .WIN_Y(win_y), .BG_RGB(bg),
        .ROM_ADDR(rom_addr2), .ROM_Q(rom_p2[2]), .VGA_CLK(vga_clk2), .VGA_HS(hs2), .VGA_VS(vs2),
        .VGA_BLANK_N(blank2), .VGA_SYNC_N(sync2), .VGA_R(r2), .VGA_G(g2), .VGA_B(b2),
        .FRAME_START(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM returns addr[7:0], registered on the falling pixel clock, ROM_LAT stages deep.
    always @(negedge vga_clk1) rom_q1 <= rom_addr1[7:0];
    always @(negedge vga_clk2) begin
        rom_p2[0] <= rom_addr2[7:0];
        rom_p2[1] <= rom_p2[0];
        rom_p2[2] <= rom_p2[1];
    end

    task automatic wait_fs(input int sel, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((sel == 1) ? fs1 : fs2) && n < 5000);
        if (!((sel == 1) ? fs1 : fs2)) begin
            $display("FAIL wait_fs%0d no FRAME_START within %0d cycles", sel, n);
            fails++;
        end
        checks++;
        cyc = 0;
        cur_div = (sel == 1) ? 2 : 4;
    endtask

    task automatic seek(input int x, input int y);
        int target;
        target = (y * H_TOT + x) * cur_div;
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        int n;
        rstn = 1'b0; mode = 2'd1; win_x = 12'd5; win_y = 12'd2; bg = 24'h123456;
        repeat (3) @(negedge clk);
        if ({hs1, vs1, blank1, fs1, vga_clk1, sync1} !== 6'b110000) begin $display("FAIL rst_ctl1 got %b exp 110000", {hs1, vs1, blank1, fs1, vga_clk1, sync1}); fails++; end checks++;
        if ({r1, g1, b1} !== 24'h0 || rom_addr1 !== 16'h0) begin $display("FAIL rst_data1 got rgb %h addr %h exp 0 0", {r1, g1, b1}, rom_addr1); fails++; end checks++;
        if ({hs2, vs2, blank2, fs2, vga_clk2, sync2} !== 6'b110000) begin $display("FAIL rst_ctl2 got %b exp 110000", {hs2, vs2, blank2, fs2, vga_clk2, sync2}); fails++; end checks++;
        rstn = 1'b1;
        wait_fs(1, n);
        if (n !== 4) begin $display("FAIL rst_latency got %0d exp 4", n); fails++; end checks++;
    endtask

    task automatic test_timing();
        int n;
        if (vga_clk1 !== 1'b1) begin $display("FAIL vga_clk_phase got %b exp 1", vga_clk1); fails++; end checks++;
        if ({r1, g1, b1} !== 24'hFFFFFF || blank1 !== 1'b1) begin $display("FAIL bar_white got %h/%b exp ffffff/1", {r1, g1, b1}, blank1); fails++; end checks++;
        seek(10, 0);
        if ({r1, g1, b1} !== 24'hFF0000) begin $display("FAIL bar_red got %h exp ff0000", {r1, g1, b1}); fails++; end checks++;
        seek(12, 0);
        if ({r1, g1, b1} !== 24'h0000FF) begin $display("FAIL bar_blue got %h exp 0000ff", {r1, g1, b1}); fails++; end checks++;
        seek(16, 0);
        if ({r1, g1, b1} !== 24'h0 || blank1 !== 1'b0) begin $display("FAIL blank_h got %h/%b exp 0/0", {r1, g1, b1}, blank1); fails++; end checks++;
        seek(17, 0);
        if (hs1 !== 1'b1) begin $display("FAIL hs_pre got %b exp 1", hs1); fails++; end checks++;
        seek(18, 0);
        if (hs1 !== 1'b0) begin $display("FAIL hs_first got %b exp 0", hs1); fails++; end checks++;
        seek(20, 0);
        if (hs1 !== 1'b0) begin $display("FAIL hs_last got %b exp 0", hs1); fails++; end checks++;
        seek(21, 0);
        if (hs1 !== 1'b1) begin $display("FAIL hs_post got %b exp 1", hs1); fails++; end checks++;
        seek(3, 1);
        if ({r1, g1, b1} !== 24'hFFFF00) begin $display("FAIL bar_yellow got %h exp ffff00", {r1, g1, b1}); fails++; end checks++;
        seek(23, 8);
        if (vs1 !== 1'b1 || blank1 !== 1'b0) begin $display("FAIL vs_pre got %b/%b exp 1/0", vs1, blank1); fails++; end checks++;
        seek(0, 9);
        if (vs1 !== 1'b0) begin $display("FAIL vs_first got %b exp 0", vs1); fails++; end checks++;
        seek(0, 10);
        if (vs1 !== 1'b0) begin $display("FAIL vs_last got %b exp 0", vs1); fails++; end checks++;
        seek(0, 11);
        if (vs1 !== 1'b1) begin $display("FAIL vs_post got %b exp 1", vs1); fails++; end checks++;
        wait_fs(1, n);
        wait_fs(1, n);
        if (n !== H_TOT * V_TOT * 2) begin $display("FAIL frame_period got %0d exp %0d", n, H_TOT * V_TOT * 2); fails++; end checks++;
    endtask

    task automatic test_window();
        int n;
        mode = 2'd0;
        wait_fs(1, n);
        seek(4, 2);
        if ({r1, g1, b1} !== 24'h123456) begin $display("FAIL win_left_bg got %h exp 123456", {r1, g1, b1}); fails++; end checks++;
        seek(5, 2);
        if ({r1, g1, b1} !== 24'h000000 || rom_addr1 !== 16'd1) begin $display("FAIL win_origin got %h addr %0d exp 000000 1", {r1, g1, b1}, rom_addr1); fails++; end checks++;
        seek(9, 2);
        if ({r1, g1, b1} !== 24'h123456) begin $display("FAIL win_right_bg got %h exp 123456", {r1, g1, b1}); fails++; end checks++;
        seek(5, 3);
        if (rom_addr1 !== 16'd5) begin $display("FAIL win_addr got %0d exp 5", rom_addr1); fails++; end checks++;
        seek(6, 3);
        if ({r1, g1, b1} !== 24'h002455) begin $display("FAIL win_pix11 got %h exp 002455", {r1, g1, b1}); fails++; end checks++;
        seek(8, 5);
        if ({r1, g1, b1} !== 24'h006DFF) begin $display("FAIL win_corner got %h exp 006dff", {r1, g1, b1}); fails++; end checks++;
        seek(8, 6);
        if ({r1, g1, b1} !== 24'h123456) begin $display("FAIL win_below_bg got %h exp 123456", {r1, g1, b1}); fails++; end checks++;
    endtask

    task automatic test_clip();
        int n;
        win_x = 12'd14; win_y = 12'd6;
        wait_fs(1, n);
        seek(14, 6);
        if ({r1, g1, b1} !== 24'h000000) begin $display("FAIL clip_origin got %h exp 000000", {r1, g1, b1}); fails++; end checks++;
        seek(1, 7);
        if ({r1, g1, b1} !== 24'h123456) begin $display("FAIL clip_nowrap got %h exp 123456", {r1, g1, b1}); fails++; end checks++;
        seek(14, 7);
        if (rom_addr1 !== 16'd5) begin $display("FAIL clip_addr_max got %0d exp 5", rom_addr1); fails++; end checks++;
        seek(15, 7);
        if ({r1, g1, b1} !== 24'h002455 || rom_addr1 !== 16'd0) begin $display("FAIL clip_edge got %h addr %0d exp 002455 0", {r1, g1, b1}, rom_addr1); fails++; end checks++;
    endtask

    task automatic test_shadow();
        int n;
        win_x = 12'd5; win_y = 12'd2;
        wait_fs(1, n);
        seek(0, 4);
        if ({r1, g1, b1} !== 24'h123456) begin $display("FAIL shadow_bg got %h exp 123456", {r1, g1, b1}); fails++; end checks++;
        mode = 2'd1;
        seek(6, 5);
        if ({r1, g1, b1} !== 24'h006D55) begin $display("FAIL shadow_hold got %h exp 006d55", {r1, g1, b1}); fails++; end checks++;
        wait_fs(1, n);
        if ({r1, g1, b1} !== 24'hFFFFFF) begin $display("FAIL shadow_next got %h exp ffffff", {r1, g1, b1}); fails++; end checks++;
    endtask

    task automatic test_mid_reset();
        int n;
        seek(0, 6);
        rstn = 1'b0;
        @(negedge clk);
        if ({hs1, vs1, blank1, fs1, vga_clk1} !== 5'b11000) begin $display("FAIL midrst_ctl got %b exp 11000", {hs1, vs1, blank1, fs1, vga_clk1}); fails++; end checks++;
        if ({r1, g1, b1} !== 24'h0 || rom_addr1 !== 16'h0) begin $display("FAIL midrst_data got rgb %h addr %h exp 0 0", {r1, g1, b1}, rom_addr1); fails++; end checks++;
        rstn = 1'b1;
        wait_fs(1, n);
        if (n !== 4) begin $display("FAIL midrst_latency got %0d exp 4", n); fails++; end checks++;
        seek(17, 0);
        if (hs1 !== 1'b1) begin $display("FAIL midrst_hs_pre got %b exp 1", hs1); fails++; end checks++;
        seek(18, 0);
        if (hs1 !== 1'b0) begin $display("FAIL midrst_hs got %b exp 0", hs1); fails++; end checks++;
    endtask

    task automatic test_rom_lat();
        int n;
        rstn = 1'b0; mode = 2'd0;
        @(negedge clk);
        rstn = 1'b1;
        wait_fs(2, n);
        if (n !== 16) begin $display("FAIL lat3_latency got %0d exp 16", n); fails++; end checks++;
        if (vga_clk2 !== 1'b1) begin $display("FAIL lat3_clk_hi got %b exp 1", vga_clk2); fails++; end checks++;
        @(negedge clk); @(negedge clk); cyc += 2;
        if (vga_clk2 !== 1'b0) begin $display("FAIL lat3_clk_lo got %b exp 0", vga_clk2); fails++; end checks++;
        seek(5, 2);
        if ({r2, g2, b2} !== 24'h000000 || rom_addr2 !== 16'd3) begin $display("FAIL lat3_origin got %h addr %0d exp 000000 3", {r2, g2, b2}, rom_addr2); fails++; end checks++;
        seek(3, 3);
        if (rom_addr2 !== 16'd5) begin $display("FAIL lat3_addr got %0d exp 5", rom_addr2); fails++; end checks++;
        seek(6, 3);
        if ({r2, g2, b2} !== 24'h002455) begin $display("FAIL lat3_pix got %h exp 002455", {r2, g2, b2}); fails++; end checks++;
        seek(15, 3);
        if (blank2 !== 1'b1) begin $display("FAIL lat3_blank_in got %b exp 1", blank2); fails++; end checks++;
        seek(16, 3);
        if (blank2 !== 1'b0) begin $display("FAIL lat3_blank_out got %b exp 0", blank2); fails++; end checks++;
        seek(17, 3);
        if (hs2 !== 1'b1) begin $display("FAIL lat3_hs_pre got %b exp 1", hs2); fails++; end checks++;
        seek(18, 3);
        if (hs2 !== 1'b0) begin $display("FAIL lat3_hs got %b exp 0", hs2); fails++; end checks++;
        wait_fs(2, n);
        wait_fs(2, n);
        if (n !== H_TOT * V_TOT * 4) begin $display("FAIL lat3_period got %0d exp %0d", n, H_TOT * V_TOT * 4); fails++; end checks++;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_window();
        test_clip();
        test_shadow();
        test_mid_reset();
        test_rom_lat();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
